// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready/data, downstream
// valid/ready/data, flush and occupancy.
interface pipe_skid_stage_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occ;

  modport master (
    output in_vld, in_data, out_rdy, flush,
    input  in_rdy, out_vld, out_data, occ
  );

  modport slave (
    input  in_vld, in_data, out_rdy, flush,
    output in_rdy, out_vld, out_data, occ
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline stage (main + skid slot). in_rdy is decoded
// from registered state only, so it never depends combinationally on out_rdy.
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rstn,
  pipe_skid_stage_if.slave  bus
);

  // Encodings double as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             main_en, skid_en, main_from_skid;
  logic             in_xfer, out_xfer;

  assign bus.in_rdy   = (state_q != StFull);
  assign bus.out_vld  = (state_q != StEmpty);
  assign bus.occ      = state_q;
  assign bus.out_data = main_q;

  assign in_xfer  = bus.in_vld & bus.in_rdy;
  assign out_xfer = bus.out_vld & bus.out_rdy;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d = StOne;
          main_en = 1'b1;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          state_d = StFull;
          skid_en = 1'b1;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_xfer) begin
          state_d        = StOne;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops everything, including a same-cycle accepted payload.
    if (bus.flush) begin
      state_d = StEmpty;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (main_en) main_q <= main_from_skid ? skid_q : bus.in_data;
      if (skid_en) skid_q <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted payloads are queued and
// compared in order against every downstream transfer.
module tb_pipe_skid_stage;
  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] exp_q[$];

  pipe_skid_stage_if #(.WIDTH(WIDTH)) ifc ();

  pipe_skid_stage #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle monitor: decides what the coming edge will do.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (ifc.out_vld && ifc.out_rdy) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
        else check_eq("sb_data", {16'h0, ifc.out_data}, {16'h0, exp_q.pop_front()});
      end
      if (ifc.flush) exp_q.delete();
      else if (ifc.in_vld && ifc.in_rdy) exp_q.push_back(ifc.in_data);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    ifc.in_vld = 1'b1;
    ifc.in_data = 16'hBEEF;
    ifc.out_rdy = 1'b0;
    ifc.flush = 1'b0;

    // Reset with upstream valid asserted
    tick();
    tick();
    check_eq("rst_out_vld", ifc.out_vld, 0);
    check_eq("rst_in_rdy", ifc.in_rdy, 1);
    check_eq("rst_occ", ifc.occ, 0);
    check_eq("rst_out_data", ifc.out_data, 0);
    rstn = 1'b1;
    ifc.in_vld = 1'b0;
    tick();

    // Streaming
    ifc.out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ifc.in_vld = 1'b1;
      ifc.in_data = WIDTH'(i);
      tick();
      check_eq("stream_data", ifc.out_data, i);
      check_eq("stream_vld", ifc.out_vld, 1);
      check_eq("stream_in_rdy", ifc.in_rdy, 1);
      check_eq("stream_occ", ifc.occ, 1);
    end
    ifc.in_vld = 1'b0;
    tick();
    check_eq("stream_drain_occ", ifc.occ, 0);

    // Backpressure
    ifc.out_rdy = 1'b0;
    ifc.in_vld = 1'b1;
    ifc.in_data = 16'h00A1;
    tick();
    check_eq("bp_occ1", ifc.occ, 1);
    ifc.in_data = 16'h00A2;
    tick();
    check_eq("bp_occ2", ifc.occ, 2);
    check_eq("bp_in_rdy", ifc.in_rdy, 0);
    ifc.in_data = 16'h00A3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_data", ifc.out_data, 16'h00A1);
      check_eq("hold_occ", ifc.occ, 2);
      check_eq("hold_in_rdy", ifc.in_rdy, 0);
    end
    ifc.out_rdy = 1'b1;
    tick();
    check_eq("rel_data_a2", ifc.out_data, 16'h00A2);
    check_eq("rel_occ", ifc.occ, 1);
    tick();
    ifc.in_vld = 1'b0;
    check_eq("rel_data_a3", ifc.out_data, 16'h00A3);
    tick();
    check_eq("rel_drain_occ", ifc.occ, 0);
    check_eq("rel_sb_empty", exp_q.size(), 0);

    // Flush from FULL with upstream valid
    ifc.out_rdy = 1'b0;
    ifc.in_vld = 1'b1;
    ifc.in_data = 16'h00B1;
    tick();
    ifc.in_data = 16'h00B2;
    tick();
    check_eq("fl_full_occ", ifc.occ, 2);
    ifc.flush = 1'b1;
    ifc.in_data = 16'h5555;
    tick();
    ifc.flush = 1'b0;
    ifc.in_vld = 1'b0;
    check_eq("fl_occ", ifc.occ, 0);
    check_eq("fl_out_vld", ifc.out_vld, 0);
    check_eq("fl_in_rdy", ifc.in_rdy, 1);

    // Flush from ONE with a same-cycle accepted payload
    ifc.in_vld = 1'b1;
    ifc.in_data = 16'h00C1;
    tick();
    check_eq("fl1_occ", ifc.occ, 1);
    ifc.flush = 1'b1;
    ifc.in_data = 16'h5555;
    tick();
    ifc.flush = 1'b0;
    ifc.in_vld = 1'b0;
    check_eq("fl1_occ0", ifc.occ, 0);
    ifc.out_rdy = 1'b1;
    tick();
    tick();
    check_eq("fl_no_emit_vld", ifc.out_vld, 0);

    // Reset mid-operation overriding flush and handshakes
    ifc.out_rdy = 1'b0;
    ifc.in_vld = 1'b1;
    ifc.in_data = 16'h00D1;
    tick();
    ifc.in_data = 16'h00D2;
    tick();
    check_eq("mr_full_occ", ifc.occ, 2);
    rstn = 1'b0;
    ifc.flush = 1'b1;
    ifc.out_rdy = 1'b1;
    ifc.in_vld = 1'b0;
    tick();
    check_eq("mr_out_vld", ifc.out_vld, 0);
    check_eq("mr_in_rdy", ifc.in_rdy, 1);
    check_eq("mr_occ", ifc.occ, 0);
    check_eq("mr_out_data", ifc.out_data, 0);
    rstn = 1'b1;
    ifc.flush = 1'b0;
    ifc.in_vld = 1'b1;
    ifc.in_data = 16'h0010;
    tick();
    ifc.in_vld = 1'b0;
    check_eq("mr_resume_data", ifc.out_data, 16'h0010);
    check_eq("mr_resume_vld", ifc.out_vld, 1);
    tick();
    check_eq("mr_resume_occ", ifc.occ, 0);
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
